// File: rtl/axi4_sram_slave.sv
// AXI4 slave in front of a byte-enabled on-chip SRAM.
// Read and write engines are independent and each handles one burst at a time.
module axi4_sram_slave #(
    parameter int N     = 1,
    parameter int I     = 1,
    parameter int DEPTH = 256
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [I-1:0]     AWID,
    input  logic [31:0]      AWADDR,
    input  logic [7:0]       AWLEN,
    input  logic [1:0]       AWBURST,
    input  logic             AWVALID,
    output logic             AWREADY,
    input  logic [8*N-1:0]   WDATA,
    input  logic [N-1:0]     WSTRB,
    input  logic             WLAST,
    input  logic             WVALID,
    output logic             WREADY,
    output logic [I-1:0]     BID,
    output logic [1:0]       BRESP,
    output logic             BVALID,
    input  logic             BREADY,
    input  logic [I-1:0]     ARID,
    input  logic [31:0]      ARADDR,
    input  logic [7:0]       ARLEN,
    input  logic [1:0]       ARBURST,
    input  logic             ARVALID,
    output logic             ARREADY,
    output logic [I-1:0]     RID,
    output logic [8*N-1:0]   RDATA,
    output logic [1:0]       RRESP,
    output logic             RLAST,
    output logic             RVALID,
    input  logic             RREADY
);
    localparam int OB = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // WRAP blocks are (LEN+1) words, so LEN itself is the in-block offset mask.
    function automatic logic [AW-1:0] next_word(input logic [AW-1:0] addr,
                                                 input logic [7:0] len,
                                                 input logic [1:0] burst);
        logic [AW-1:0] mask;
        mask = AW'(len);
        case (burst)
            BURST_FIXED: next_word = addr;
            BURST_INCR:  next_word = addr + AW'(1);
            BURST_WRAP:  next_word = (addr & ~mask) | ((addr + AW'(1)) & mask);
            default:     next_word = addr;
        endcase
    endfunction

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        case (burst)
            BURST_WRAP: burst_err = !((len == 8'd1) || (len == 8'd3) ||
                                      (len == 8'd7) || (len == 8'd15));
            2'b11:      burst_err = 1'b1;
            default:    burst_err = 1'b0;
        endcase
    endfunction

    logic [8*N-1:0] mem [DEPTH];

    w_state_t       w_state_r, w_state_nxt;
    logic [AW-1:0]  w_addr_r;
    logic [7:0]     w_len_r, w_cnt_r;
    logic [1:0]     w_burst_r;
    logic [I-1:0]   w_id_r;
    logic           w_err_r, w_bad_r;
    logic           aw_hs_s, w_hs_s, b_hs_s, w_final_s, wlast_bad_s;
    logic           awready_r, wready_r, bvalid_r;
    logic [I-1:0]   bid_r;
    logic [1:0]     bresp_r;

    r_state_t       r_state_r, r_state_nxt;
    logic [AW-1:0]  r_addr_r, rd_word_s;
    logic [7:0]     r_len_r, r_cnt_r;
    logic [1:0]     r_burst_r;
    logic           r_err_r, ar_hs_s, r_hs_s, ar_err_s;
    logic           arready_r, rvalid_r, rlast_r;
    logic [I-1:0]   rid_r;
    logic [1:0]     rresp_r;
    logic [8*N-1:0] rdata_r, mem_rd_s;
    logic           unused_s;

    assign unused_s    = ^{AWADDR, ARADDR};
    assign w_final_s   = (w_cnt_r == w_len_r);
    assign wlast_bad_s = (WLAST != w_final_s);
    assign ar_err_s    = burst_err(ARBURST, ARLEN);

    // Write FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) w_state_r <= W_IDLE;
        else        w_state_r <= w_state_nxt;
    end

    // Write FSM next state and handshake decode.
    always_comb begin
        w_state_nxt = w_state_r;
        aw_hs_s     = 1'b0;
        w_hs_s      = 1'b0;
        b_hs_s      = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (AWVALID && awready_r) begin
                    aw_hs_s     = 1'b1;
                    w_state_nxt = W_DATA;
                end else begin
                    w_state_nxt = W_IDLE;
                end
            end
            W_DATA: begin
                if (WVALID && wready_r) begin
                    w_hs_s      = 1'b1;
                    w_state_nxt = w_final_s ? W_RESP : W_DATA;
                end else begin
                    w_state_nxt = W_DATA;
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_r) begin
                    b_hs_s      = 1'b1;
                    w_state_nxt = W_IDLE;
                end else begin
                    w_state_nxt = W_RESP;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write burst context, registered ready flags and the B channel.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_addr_r  <= '0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_burst_r <= 2'b00;
            w_id_r    <= '0;
            w_err_r   <= 1'b0;
            w_bad_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= RESP_OKAY;
        end else begin
            awready_r <= (w_state_nxt == W_IDLE);
            wready_r  <= (w_state_nxt == W_DATA);
            if (aw_hs_s) begin
                w_addr_r  <= AWADDR[OB+AW-1:OB];
                w_len_r   <= AWLEN;
                w_cnt_r   <= 8'd0;
                w_burst_r <= AWBURST;
                w_id_r    <= AWID;
                w_err_r   <= burst_err(AWBURST, AWLEN);
                w_bad_r   <= 1'b0;
            end else if (w_hs_s) begin
                w_addr_r <= next_word(w_addr_r, w_len_r, w_burst_r);
                w_cnt_r  <= w_cnt_r + 8'd1;
                w_bad_r  <= w_bad_r | wlast_bad_s;
                if (w_final_s) begin
                    bvalid_r <= 1'b1;
                    bid_r    <= w_id_r;
                    bresp_r  <= (w_err_r || w_bad_r || wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    bvalid_r <= bvalid_r;
                end
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
            end else begin
                bvalid_r <= bvalid_r;
            end
        end
    end

    // SRAM write port; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (w_hs_s && !w_err_r) begin
            for (int b = 0; b < N; b++) begin
                if (WSTRB[b]) mem[w_addr_r][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state_r <= R_IDLE;
        else        r_state_r <= r_state_nxt;
    end

    // Read FSM next state, handshake decode and the word to fetch next.
    always_comb begin
        r_state_nxt = r_state_r;
        ar_hs_s     = 1'b0;
        r_hs_s      = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (ARVALID && arready_r) begin
                    ar_hs_s     = 1'b1;
                    r_state_nxt = R_DATA;
                end else begin
                    r_state_nxt = R_IDLE;
                end
            end
            R_DATA: begin
                if (RVALID && RREADY) begin
                    r_hs_s      = 1'b1;
                    r_state_nxt = rlast_r ? R_IDLE : R_DATA;
                end else begin
                    r_state_nxt = R_DATA;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
        if (ar_hs_s) rd_word_s = ARADDR[OB+AW-1:OB];
        else         rd_word_s = next_word(r_addr_r, r_len_r, r_burst_r);
        mem_rd_s = mem[rd_word_s];
    end

    // R channel: a beat is prefetched on AR accept and on each accepted non-last beat.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_addr_r  <= '0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_burst_r <= 2'b00;
            r_err_r   <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= '0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= '0;
        end else begin
            arready_r <= (r_state_nxt == R_IDLE);
            if (ar_hs_s) begin
                r_addr_r  <= rd_word_s;
                r_len_r   <= ARLEN;
                r_cnt_r   <= 8'd0;
                r_burst_r <= ARBURST;
                r_err_r   <= ar_err_s;
                rid_r     <= ARID;
                rvalid_r  <= 1'b1;
                rlast_r   <= (ARLEN == 8'd0);
                rresp_r   <= ar_err_s ? RESP_SLVERR : RESP_OKAY;
                rdata_r   <= ar_err_s ? '0 : mem_rd_s;
            end else if (r_hs_s && rlast_r) begin
                rvalid_r <= 1'b0;
                rlast_r  <= 1'b0;
            end else if (r_hs_s) begin
                r_addr_r <= rd_word_s;
                r_cnt_r  <= r_cnt_r + 8'd1;
                rlast_r  <= ((r_cnt_r + 8'd1) == r_len_r);
                rdata_r  <= r_err_r ? '0 : mem_rd_s;
            end else begin
                rvalid_r <= rvalid_r;
            end
        end
    end

    assign AWREADY = awready_r;
    assign WREADY  = wready_r;
    assign BVALID  = bvalid_r;
    assign BID     = bid_r;
    assign BRESP   = bresp_r;
    assign ARREADY = arready_r;
    assign RVALID  = rvalid_r;
    assign RLAST   = rlast_r;
    assign RID     = rid_r;
    assign RRESP   = rresp_r;
    assign RDATA   = rdata_r;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave with N=4: bursts, strobes, stalls, errors and reset.
module tb_axi4_sram_slave;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] wdat [16];
    logic [31:0] rexp [16];

    always #5 ACLK = ~ACLK;

    axi4_sram_slave #(.N(4), .I(4), .DEPTH(256)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb, input bit nolast,
                            input logic [1:0] exp_resp);
        int t;
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
        chk("aw_ready", AWREADY, 1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            WDATA = wdat[b]; WSTRB = strb; WLAST = nolast ? 1'b0 : (b == int'(len)); WVALID = 1'b1;
            t = 0;
            while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
            if (!WREADY) chk("w_ready", WREADY, 1);
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        t = 0;
        while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
        chk("b_valid", BVALID, 1);
        chk("bid", BID, id);
        chk("bresp", BRESP, exp_resp);
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("b_drop", BVALID, 0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [1:0] exp_resp,
                           input int rdelay, input bit toggle);
        int t, beat, cyc;
        bit ph, stalled;
        logic [31:0] held;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1; RREADY = 1'b0;
        t = 0;
        while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
        chk("ar_ready", ARREADY, 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("r_latency", RVALID, 1);
        for (int d = 0; d < rdelay; d++) begin
            held = RDATA;
            @(negedge ACLK);
            chk("r_hold", RDATA, held);
        end
        beat = 0; cyc = 0; ph = 1'b1; stalled = 1'b0; held = '0;
        while (beat <= int'(len) && cyc < 200) begin
            if (stalled) chk("r_stall_stable", RDATA, held);
            stalled = 1'b0;
            RREADY = toggle ? ph : 1'b1;
            ph = !ph;
            if (RVALID && RREADY) begin
                chk("rdata", RDATA, rexp[beat]);
                chk("rresp", RRESP, exp_resp);
                chk("rid", RID, id);
                chk("rlast", RLAST, (beat == int'(len)));
                beat++;
            end else if (RVALID) begin
                stalled = 1'b1;
                held = RDATA;
            end
            @(negedge ACLK);
            cyc++;
        end
        RREADY = 1'b0;
        chk("r_beats", beat, int'(len) + 1);
        chk("r_done", RVALID, 0);
    endtask

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0); chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);   chk("rst_rlast", RLAST, 0);
        chk("rst_bid", BID, 0);         chk("rst_rid", RID, 0);
        chk("rst_bresp", BRESP, 0);     chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // INCR write 1..4 at 0x10, read back
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); rexp[i] = 32'(i + 1); end
        do_write(4'd3, 32'h10, 8'd3, 2'b01, 4'hF, 1'b0, 2'b00);
        do_read(4'd5, 32'h10, 8'd3, 2'b01, 2'b00, 0, 1'b0);

        // WRAP write LEN=3 at 0x18 hits words 6,7,4,5
        for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + 32'(i);
        do_write(4'd1, 32'h18, 8'd3, 2'b10, 4'hF, 1'b0, 2'b00);
        rexp[0] = 32'hA2; rexp[1] = 32'hA3; rexp[2] = 32'hA0; rexp[3] = 32'hA1;
        do_read(4'd2, 32'h10, 8'd3, 2'b01, 2'b00, 0, 1'b0);
        rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
        do_read(4'd6, 32'h18, 8'd3, 2'b10, 2'b00, 0, 1'b0);
        for (int i = 0; i < 3; i++) rexp[i] = 32'h0;
        do_read(4'd7, 32'h18, 8'd2, 2'b10, 2'b10, 0, 1'b0);

        // FIXED read repeats word 4; high address bits alias modulo DEPTH
        rexp[0] = 32'hA2; rexp[1] = 32'hA2;
        do_read(4'd8, 32'h10, 8'd1, 2'b00, 2'b00, 0, 1'b0);
        do_read(4'd9, 32'h410, 8'd0, 2'b01, 2'b00, 0, 1'b0);

        // Partial strobe merge
        wdat[0] = 32'hAABBCCDD;
        do_write(4'd4, 32'h40, 8'd0, 2'b01, 4'hF, 1'b0, 2'b00);
        wdat[0] = 32'h11223344;
        do_write(4'd4, 32'h40, 8'd0, 2'b01, 4'h5, 1'b0, 2'b00);
        rexp[0] = 32'hAA22CC44;
        do_read(4'd4, 32'h40, 8'd0, 2'b01, 2'b00, 0, 1'b0);

        // RREADY toggling after a 3-cycle delay
        rexp[0] = 32'hA2; rexp[1] = 32'hA3; rexp[2] = 32'hA0; rexp[3] = 32'hA1;
        do_read(4'd10, 32'h10, 8'd3, 2'b01, 2'b00, 3, 1'b1);

        // Missing WLAST still writes but flags SLVERR; reserved burst writes nothing
        wdat[0] = 32'h55; wdat[1] = 32'h66;
        do_write(4'd11, 32'h80, 8'd1, 2'b01, 4'hF, 1'b1, 2'b10);
        wdat[0] = 32'hDEAD;
        do_write(4'd12, 32'h80, 8'd0, 2'b11, 4'hF, 1'b0, 2'b10);
        rexp[0] = 32'h55; rexp[1] = 32'h66;
        do_read(4'd13, 32'h80, 8'd1, 2'b01, 2'b00, 0, 1'b0);

        // Concurrent LEN=15 read and write on disjoint regions
        for (int i = 0; i < 16; i++) wdat[i] = 32'h1000 + 32'(i);
        do_write(4'd14, 32'h100, 8'd15, 2'b01, 4'hF, 1'b0, 2'b00);
        for (int i = 0; i < 16; i++) begin rexp[i] = 32'h1000 + 32'(i); wdat[i] = 32'h2000 + 32'(i); end
        fork
            do_write(4'd15, 32'h200, 8'd15, 2'b01, 4'hF, 1'b0, 2'b00);
            do_read(4'd0, 32'h100, 8'd15, 2'b01, 2'b00, 0, 1'b0);
        join
        for (int i = 0; i < 16; i++) rexp[i] = 32'h2000 + 32'(i);
        do_read(4'd1, 32'h200, 8'd15, 2'b01, 2'b00, 0, 1'b0);

        // Reset pulse in the middle of a write burst
        AWID = 4'd2; AWADDR = 32'h300; AWLEN = 8'd3; AWBURST = 2'b01; AWVALID = 1'b1;
        while (!AWREADY) @(negedge ACLK);
        @(negedge ACLK);
        AWVALID = 1'b0;
        WSTRB = 4'hF; WVALID = 1'b1; WLAST = 1'b0; WDATA = 32'h77;
        for (int k = 0; k < 50 && !WREADY; k++) @(negedge ACLK);
        @(negedge ACLK);
        WDATA = 32'h88;
        @(negedge ACLK);
        WVALID = 1'b0;
        ARESET = 1'b1;
        #1;
        chk("mid_rst_awready", AWREADY, 0);
        chk("mid_rst_wready", WREADY, 0);
        chk("mid_rst_bvalid", BVALID, 0);
        chk("mid_rst_arready", ARREADY, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        wdat[0] = 32'h99;
        do_write(4'd3, 32'h304, 8'd0, 2'b01, 4'hF, 1'b0, 2'b00);
        rexp[0] = 32'h77; rexp[1] = 32'h99;
        do_read(4'd3, 32'h300, 8'd1, 2'b01, 2'b00, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
